// File: rtl/ctr_game_param.sv
// Parametrised up/down counter game: scores exact landings on all-ones (WINNER)
// and zero (LOSER), and freezes once either score reaches GAMEOVER_COUNT.
module ctr_game_param #(
  parameter int WIDTH          = 4,
  parameter int SCORE_W        = 4,
  parameter int GAMEOVER_COUNT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               INIT,
  input  logic [1:0]         control,
  input  logic [WIDTH-1:0]   initial_value,
  output logic [WIDTH-1:0]   count,
  output logic               WINNER,
  output logic               LOSER,
  output logic [SCORE_W-1:0] winner_score,
  output logic [SCORE_W-1:0] loser_score,
  output logic               GAMEOVER,
  output logic [1:0]         WHO
);

  generate
    if (WIDTH < 2 || GAMEOVER_COUNT < 1 || GAMEOVER_COUNT > (2 ** SCORE_W) - 1) begin : g_param_check
      $error("ctr_game_param: illegal WIDTH or GAMEOVER_COUNT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0]   ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ZERO_CNT  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   STEP1     = WIDTH'(1);
  localparam logic [WIDTH-1:0]   STEP2     = WIDTH'(2);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_END = SCORE_W'(GAMEOVER_COUNT);

  state_t             state_r;
  logic [WIDTH-1:0]   count_r;
  logic               winner_r;
  logic               loser_r;
  logic [SCORE_W-1:0] winner_score_r;
  logic [SCORE_W-1:0] loser_score_r;
  logic               gameover_r;
  logic [1:0]         who_r;

  logic [WIDTH-1:0]   next_count_s;
  logic               win_hit_s;
  logic               lose_hit_s;
  logic [SCORE_W-1:0] winner_inc_s;
  logic [SCORE_W-1:0] loser_inc_s;

  // Next count for the selected step mode; arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    next_count_s = count_r;
    case (control)
      2'b00:   next_count_s = count_r + STEP1;
      2'b01:   next_count_s = count_r + STEP2;
      2'b10:   next_count_s = count_r - STEP1;
      2'b11:   next_count_s = count_r - STEP2;
      default: next_count_s = count_r;
    endcase
    win_hit_s    = (next_count_s == ALL_ONES);
    lose_hit_s   = (next_count_s == ZERO_CNT);
    winner_inc_s = winner_score_r + SCORE_ONE;
    loser_inc_s  = loser_score_r + SCORE_ONE;
  end

  // Game FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      count_r        <= ZERO_CNT;
      winner_r       <= 1'b0;
      loser_r        <= 1'b0;
      winner_score_r <= {SCORE_W{1'b0}};
      loser_score_r  <= {SCORE_W{1'b0}};
      gameover_r     <= 1'b0;
      who_r          <= 2'b00;
    end else begin
      winner_r <= 1'b0;
      loser_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (INIT) begin
            count_r <= initial_value;
            state_r <= RUN;
          end else begin
            count_r <= ZERO_CNT;
          end
        end
        RUN: begin
          if (INIT) begin
            count_r <= initial_value;
          end else begin
            count_r  <= next_count_s;
            winner_r <= win_hit_s;
            loser_r  <= lose_hit_s;
            if (win_hit_s) begin
              winner_score_r <= winner_inc_s;
              if (winner_inc_s == SCORE_END) begin
                gameover_r <= 1'b1;
                who_r      <= 2'b10;
                state_r    <= OVER;
              end
            end else if (lose_hit_s) begin
              loser_score_r <= loser_inc_s;
              if (loser_inc_s == SCORE_END) begin
                gameover_r <= 1'b1;
                who_r      <= 2'b01;
                state_r    <= OVER;
              end
            end else begin
              state_r <= RUN;
            end
          end
        end
        OVER: begin
          if (INIT) begin
            count_r        <= initial_value;
            winner_score_r <= {SCORE_W{1'b0}};
            loser_score_r  <= {SCORE_W{1'b0}};
            gameover_r     <= 1'b0;
            who_r          <= 2'b00;
            state_r        <= RUN;
          end else begin
            gameover_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign count        = count_r;
  assign WINNER       = winner_r;
  assign LOSER        = loser_r;
  assign winner_score = winner_score_r;
  assign loser_score  = loser_score_r;
  assign GAMEOVER     = gameover_r;
  assign WHO          = who_r;

endmodule

// File: tb/tb_ctr_game_param.sv
// Self-checking bench for ctr_game_param: directed scenarios plus random
// stimulus, all compared against an arithmetic model of the game rules.
module tb_ctr_game_param;
  localparam int WIDTH = 4;
  localparam int SCORE_W = 4;
  localparam int GC = 15;
  localparam int MAXV = 2 ** WIDTH;

  logic clock = 1'b0;
  logic reset_n, INIT;
  logic [1:0] control;
  logic [WIDTH-1:0] initial_value;
  logic [WIDTH-1:0] count;
  logic WINNER, LOSER, GAMEOVER;
  logic [SCORE_W-1:0] winner_score, loser_score;
  logic [1:0] WHO;

  int checks = 0;
  int errors = 0;

  // model of the game: plain integers
  int m_cnt, m_ws, m_ls;
  bit m_started, m_over, m_win, m_lose;
  logic [1:0] m_who;

  ctr_game_param #(.WIDTH(WIDTH), .SCORE_W(SCORE_W), .GAMEOVER_COUNT(GC)) dut (
    .clock(clock), .reset_n(reset_n), .INIT(INIT), .control(control),
    .initial_value(initial_value), .count(count), .WINNER(WINNER), .LOSER(LOSER),
    .winner_score(winner_score), .loser_score(loser_score), .GAMEOVER(GAMEOVER), .WHO(WHO)
  );

  always #5 clock = ~clock;

  function automatic logic [16:0] exp_vec();
    return {m_cnt[WIDTH-1:0], m_win, m_lose, m_ws[SCORE_W-1:0], m_ls[SCORE_W-1:0], m_over, m_who};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {count, WINNER, LOSER, winner_score, loser_score, GAMEOVER, WHO};
  endfunction

  task automatic model_update(input logic rn, input logic init, input logic [1:0] ctl, input int iv);
    int delta;
    m_win = 1'b0;
    m_lose = 1'b0;
    if (!rn) begin
      m_cnt = 0; m_ws = 0; m_ls = 0; m_started = 0; m_over = 0; m_who = 2'b00;
    end else if (init) begin
      if (m_over) begin
        m_ws = 0; m_ls = 0; m_who = 2'b00;
      end
      m_cnt = iv; m_started = 1; m_over = 0;
    end else if (m_started && !m_over) begin
      delta = (ctl == 2'b00) ? 1 : (ctl == 2'b01) ? 2 : (ctl == 2'b10) ? -1 : -2;
      m_cnt = ((m_cnt + delta) % MAXV + MAXV) % MAXV;
      m_win = (m_cnt == MAXV - 1);
      m_lose = (m_cnt == 0);
      if (m_win) m_ws++;
      if (m_lose) m_ls++;
      if (m_ws == GC) begin m_over = 1; m_who = 2'b10; end
      else if (m_ls == GC) begin m_over = 1; m_who = 2'b01; end
    end
  endtask

  task automatic drive(input logic rn, input logic init, input logic [1:0] ctl, input int iv);
    reset_n = rn; INIT = init; control = ctl; initial_value = iv[WIDTH-1:0];
    @(posedge clock);
    model_update(rn, init, ctl, iv);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 2'b01, 9);
    drive(1'b0, 1'b0, 2'b00, 0);
    checks++;
    if (dut_vec() !== 17'd0) begin
      errors++; $display("FAIL reset: got %h expected %h", dut_vec(), 17'd0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 2'($urandom_range(3)), int'($urandom_range(MAXV - 1)));
      checks++;
      if (dut_vec() !== 17'd0) begin
        errors++; $display("FAIL idle cyc %0d: got %h expected %h", i, dut_vec(), 17'd0);
      end
    end
  endtask

  task automatic test_step_plus2();
    int exp_c[5] = '{11, 13, 15, 1, 3};
    drive(1'b0, 1'b0, 2'b00, 0);
    drive(1'b1, 1'b1, 2'b00, 9);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 2'b01, 0);
      checks++;
      if (count !== exp_c[i][WIDTH-1:0] || WINNER !== (exp_c[i] == 15) || LOSER !== 1'b0 ||
          dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL plus2 step %0d: got count %0d W %b L %b vec %h, expected count %0d vec %h",
                 i, count, WINNER, LOSER, dut_vec(), exp_c[i], exp_vec());
      end
    end
    checks++;
    if (winner_score !== 4'd1) begin
      errors++; $display("FAIL plus2 score: got %0d expected 1", winner_score);
    end
  endtask

  task automatic test_step_minus2();
    int exp_a[3] = '{1, 15, 13};
    drive(1'b0, 1'b0, 2'b00, 0);
    drive(1'b1, 1'b1, 2'b00, 3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'b11, 0);
      checks++;
      if (count !== exp_a[i][WIDTH-1:0] || WINNER !== (i == 1) || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL minus2 a step %0d: got count %0d W %b vec %h expected count %0d vec %h",
                 i, count, WINNER, dut_vec(), exp_a[i], exp_vec());
      end
    end
    drive(1'b1, 1'b1, 2'b11, 2);
    drive(1'b1, 1'b0, 2'b11, 0);
    checks++;
    if (count !== 4'd0 || LOSER !== 1'b1 || loser_score !== 4'd1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL minus2 land0: got %h expected %h", dut_vec(), exp_vec());
    end
    drive(1'b1, 1'b0, 2'b11, 0);
    checks++;
    if (count !== 4'd14 || LOSER !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL minus2 wrap: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_gameover();
    drive(1'b0, 1'b0, 2'b00, 0);
    drive(1'b1, 1'b1, 2'b00, 0);
    for (int c = 1; c <= 239; c++) begin
      drive(1'b1, 1'b0, 2'b00, 0);
      checks++;
      if (dut_vec() !== exp_vec() || WINNER !== (c % 16 == 15)) begin
        errors++; $display("FAIL gameover cyc %0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
      if (c == 224) begin
        checks++;
        if (loser_score !== 4'd14) begin
          errors++; $display("FAIL loser14: got %0d expected 14", loser_score);
        end
      end
    end
    checks++;
    if (winner_score !== 4'd15 || GAMEOVER !== 1'b1 || WHO !== 2'b10) begin
      errors++;
      $display("FAIL gameover end: got ws %0d go %b who %b expected 15 1 10", winner_score, GAMEOVER, WHO);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 2'($urandom_range(3)), 0);
      checks++;
      if (count !== 4'd15 || GAMEOVER !== 1'b1 || WINNER !== 1'b0 || LOSER !== 1'b0 ||
          dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL frozen cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_restart();
    drive(1'b1, 1'b1, 2'b00, 5);
    checks++;
    if (count !== 4'd5 || winner_score !== 4'd0 || loser_score !== 4'd0 ||
        GAMEOVER !== 1'b0 || WHO !== 2'b00) begin
      errors++; $display("FAIL restart: got %h expected count 5 cleared", dut_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'b00, 0);
      checks++;
      if (count !== 4'(6 + i) || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL resume %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 2'b00, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 2'b00, 13);
      drive(1'b1, 1'b0, 2'b01, 0);
    end
    drive(1'b1, 1'b1, 2'b00, 7);
    checks++;
    if (count !== 4'd7 || winner_score !== 4'd3) begin
      errors++; $display("FAIL midsetup: got count %0d ws %0d expected 7 3", count, winner_score);
    end
    drive(1'b0, 1'b1, 2'b00, 9);
    checks++;
    if (dut_vec() !== 17'd0) begin
      errors++; $display("FAIL midreset: got %h expected %h", dut_vec(), 17'd0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 2'($urandom_range(3)), 0);
      checks++;
      if (dut_vec() !== 17'd0) begin
        errors++; $display("FAIL stopped %0d: got %h expected %h", i, dut_vec(), 17'd0);
      end
    end
  endtask

  task automatic test_random();
    logic rn, init;
    drive(1'b0, 1'b0, 2'b00, 0);
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(199) != 0);
      init = ($urandom_range(15) == 0);
      drive(rn, init, 2'($urandom_range(3)), int'($urandom_range(MAXV - 1)));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; INIT = 1'b0; control = 2'b00; initial_value = '0;
    m_cnt = 0; m_ws = 0; m_ls = 0; m_started = 0; m_over = 0; m_win = 0; m_lose = 0; m_who = 2'b00;
    test_reset();
    test_step_plus2();
    test_step_minus2();
    test_gameover();
    test_restart();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctr_game_param.md
Name: ctr_game_param

Overview:
- Parametrised successor of the 4-bit counter game: a WIDTH-bit up/down counter with four step modes.
- Counts landings on all-ones as WINNER events and landings on zero as LOSER events.
- Declares GAMEOVER when either score reaches GAMEOVER_COUNT, then freezes until re-initialised.
- Sits between the player-control logic and the score display, and is driven by a testbench-style stimulus source.

Parameters:
- WIDTH, 4, counter width in bits; must be ≥ 2.
- SCORE_W, 4, width of each score counter.
- GAMEOVER_COUNT, 15, score value that ends the game; range 1..2^SCORE_W-1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- INIT  in  1  load request; active high.
- control  in  2  step mode: 00 = +1, 01 = +2, 10 = -1, 11 = -2.
- initial_value  in  WIDTH  value loaded on INIT.
- count  out  WIDTH  current counter value (registered).
- WINNER  out  1  one-cycle pulse; count has just landed on all-ones.
- LOSER  out  1  one-cycle pulse; count has just landed on zero.
- winner_score  out  SCORE_W  number of WINNER events this game.
- loser_score  out  SCORE_W  number of LOSER events this game.
- GAMEOVER  out  1  high while the game is over.
- WHO  out  2  game result: 00 = none, 10 = winner side reached limit, 01 = loser side reached limit.

Behaviour:
- Reset: reset_n = 0 at a rising edge clears count, WINNER, LOSER, both scores, GAMEOVER and WHO to 0, and sets state to IDLE. Reset overrides INIT and every other input, including mid-game and in OVER.
- FSM states: IDLE, RUN, OVER.
- IDLE:
  - count holds at 0; no flags are raised.
  - INIT = 1 → count <= initial_value, state <= RUN.
- RUN with INIT = 1:
  - count <= initial_value; scores are kept.
  - WINNER and LOSER are 0 that cycle. A load never raises a flag, even if initial_value is all-ones or 0.
- RUN with INIT = 0:
  - count <= count ± step per control, modulo 2^WIDTH (wraps both directions).
  - If the new count is all-ones: WINNER = 1 and winner_score += 1, in the same edge.
  - If the new count is 0: LOSER = 1 and loser_score += 1, in the same edge.
  - Flags are aligned with the registered count and last exactly one cycle.
  - Flags fire only on an exact landing. A +2/-2 step that jumps over all-ones or 0 raises no flag; e.g. WIDTH = 4, 14 + 2 = 0 raises LOSER only.
- Game over:
  - Trigger: the edge on which winner_score becomes GAMEOVER_COUNT (or loser_score does).
  - Same edge: GAMEOVER <= 1 and WHO <= 10 (or 01), state <= OVER.
  - WINNER/LOSER still pulse on that edge.
  - WINNER and LOSER cannot occur together because all-ones ≠ 0 for WIDTH ≥ 2.
- OVER:
  - count, scores and WHO are frozen; GAMEOVER is held at 1; WINNER/LOSER are 0.
  - control is ignored.
  - INIT = 1 → count <= initial_value; scores, GAMEOVER and WHO clear to 0; state <= RUN.
- Latency: one clock from input to every output; there are no combinational paths from inputs to outputs.
- Parameter violations (WIDTH < 2, GAMEOVER_COUNT out of range) are flagged by an elaboration-time check.

Test Plan:
- Reset/IDLE: hold reset_n = 0 for 2 cycles, then INIT = 0 for 5 cycles → count = 0, all flags and scores 0, no WINNER/LOSER.
- Step +2 with wrap: INIT load 9, then control = 01 → count 11, 13, 15 (WINNER = 1, winner_score = 1), 1, 3; no LOSER pulse on the wrap past 0.
- Step -2 landing and skip: load 3, control = 11 → 1, 15 (WINNER), 13; then load 2, control = 11 → 0 (LOSER = 1, loser_score = 1), 14.
- Game over: load 0, control = 00 for 239 cycles →
  - WINNER at cycles 15, 31, …;
  - loser_score = 14 at cycle 224;
  - at cycle 239: winner_score = 15, GAMEOVER = 1, WHO = 10;
  - count stays 15 for the next 20 cycles.
- Restart from OVER: after GAMEOVER, INIT = 1 with initial_value = 5 → next cycle count = 5, scores 0, GAMEOVER = 0, WHO = 00, counting resumes.
- Reset mid-operation: in RUN with winner_score = 3 and count = 7, pull reset_n = 0 for one edge → all outputs 0, state IDLE; counting stays stopped until INIT.
